ssd_scan_controller: RTL
========================

# ssd_scan_controller

Time-multiplexing scheduler for the 4-digit common-anode seven-segment display. It replaces the free-running refresh counter, anode-select and digit-mux chain with one sequenced block. The block accepts a 16-bit hex value plus 4 decimal points over a valid/ready handshake and double-buffers it, so the visible value only changes at frame boundaries. Each digit slot begins with an anti-ghosting blank interval. It sits between board-level value producers and the Anode/Cathode/dp pins.

## Interface
- DIGIT_CYCLES, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be ≥ 4.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer offers wr_data/wr_dp.
- wr_ready  output  1  block can accept a new value.
- wr_data  input  16  four hex digits; [3:0] drives digit 0 (rightmost, Anode[0]).
- wr_dp  input  4  decimal points, bit n for digit n, 1 = lit.
- Anode  output  4  active-low digit enables.
- Cathode  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- frame_start  output  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Slot counter cnt runs 0..DIGIT_CYCLES-1. Digit index dig runs 0..3 and advances when cnt wraps. dig wraps 3→0.
- Per-slot FSM:
  - BLANK for cnt < BLANK_CYCLES: Anode=4'b1111, Cathode=7'h7F, dp=1.
  - DRIVE for the rest of the slot: Anode has only bit dig low; Cathode = segments of active nibble dig; dp = ~active_dp[dig].
- Hex decode covers 0–F (A,b,C,d,E,F glyphs).
- Handshake: transfer occurs when wr_valid & wr_ready. The value is captured into the shadow register and pending is set.
  - wr_ready = ~pending.
  - The producer holds wr_valid/wr_data stable until transfer.
- Commit: on the last cycle of digit 3's slot (dig=3, cnt=DIGIT_CYCLES-1), if pending is set, active ← shadow and pending clears.
- Simultaneous commit and wr_valid: wr_ready is 0 that cycle, so there is no transfer. Transfer occurs on the next cycle.
- Writes arriving while pending is set stall; they are never dropped or overwritten.
- Reset mid-operation: the pending shadow is discarded, active is cleared to 0, and the scan restarts at digit 0 BLANK.

## Timing
- Reset values:
  - Anode=4'b1111, Cathode=7'h7F, dp=1, frame_start=0, wr_ready=1.
  - cnt=0, dig=0, active=0, active_dp=0, pending=0.
- Anode, Cathode, dp and frame_start are registered: they reflect the cnt/dig of the previous cycle (1-cycle latency).
- frame_start is high in the cycle after cnt=0 with dig=0, including the first frame after reset deassert.
- wr_ready drops in the cycle after a transfer. It rises in the cycle after commit.
- Frame period = 4·DIGIT_CYCLES.
- Transfer-to-visible latency: value commits at the next frame boundary, then appears on digit 0 BLANK_CYCLES+1 cycles after that boundary.

## Configuration
- SSD_LZ_BLANK_EN defined: leading-zero blanking.
  - Digit n (n=3..1) is suppressed when its nibble and all higher nibbles of active are 0, and its dp bit and all higher dp bits are 0.
  - A suppressed digit keeps Anode all-high for its entire slot.
  - Digit 0 is always driven.
- Undefined: all four digits are driven every frame.
- Handshake and timing are identical in both builds.

## Structure
- Package ssd_pkg holds:
  - NUM_DIGITS=4
  - the slot-FSM state enum (BLANK, DRIVE)
  - the 16-entry active-low segment constant table
  - the SEG_OFF=7'h7F and AN_OFF=4'hF constants.
- Sub-module ssd_hex_seg: combinational 4-bit → 7-segment decoder built from the package table.
- Counter, FSM, buffering and output registers live in ssd_scan_controller.

## Test plan
Parameters for all scenarios: DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Reset, then 40 cycles idle -> Anode sequence per slot: 1111 for 2 cycles, then 1110, 1101, 1011, 0111 for 6 cycles each; Cathode=7'h40 ("0") in DRIVE; frame_start period 32.
- Write wr_data=16'h1A2F, wr_dp=4'b0100 mid-frame -> wr_ready low until the frame boundary. Next frame shows:
  - digit0 F=7'h0E, digit1 2=7'h24, digit2 A=7'h08 with dp=0, digit3 1=7'h79.
- Back-to-back writes 16'h1111 then 16'h2222 with wr_valid held -> the second stalls until the first commits; the display shows 1111 for exactly one frame, then 2222.
- wr_valid asserted exactly on the commit cycle -> no transfer that cycle; transfer on the next cycle; the value displays one frame later.
- Assert reset during digit 2 DRIVE with a write pending -> next cycle all reset values hold; the pending value never appears.
- With SSD_LZ_BLANK_EN, write 16'h0030, wr_dp=0 -> digit 3 and digit 2 anodes stay 1111 for their whole slots; digits 1 and 0 show "3" and "0".

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, slot-state enum and segment table for the seven-segment scan controller
package ssd_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  typedef enum logic {BLANK, DRIVE} slot_state_t;
  // active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/ssd_scan_controller_if.sv
// ssd_scan_controller_if: valid/ready write channel carrying four hex digits and their decimal points
interface ssd_scan_controller_if;
  logic wr_valid;
  logic wr_ready;
  logic [15:0] wr_data;
  logic [3:0] wr_dp;
  modport master(output wr_valid, output wr_data, output wr_dp, input wr_ready);
  modport slave(input wr_valid, input wr_data, input wr_dp, output wr_ready);
endinterface

// File: rtl/ssd_hex_seg.sv
// ssd_hex_seg: combinational hex nibble to active-low seven-segment decoder
module ssd_hex_seg
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: double-buffered 4-digit seven-segment scanner with per-slot anti-ghosting blank.
// Define SSD_LZ_BLANK_EN to suppress leading zero digits (digit 0 is always driven).
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  ssd_scan_controller_if.slave wr,
  output logic [3:0] Anode,
  output logic [6:0] Cathode,
  output logic dp,
  output logic frame_start
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);
  logic [CW-1:0] cnt, cnt_d;
  logic [DW-1:0] dig;
  logic [15:0] active, shadow;
  logic [3:0] active_dp, shadow_dp;
  logic pending, slot_end, commit, take, drive_en, dp_d;
  logic [3:0] nib, an_d, lz_off;
  logic [6:0] seg, cat_d;
  slot_state_t state, state_d;
  assign slot_end = cnt == CW'(DIGIT_CYCLES - 1);
  assign commit = slot_end && dig == DW'(NUM_DIGITS - 1) && pending;
  assign take = wr.wr_valid && !pending;
  assign wr.wr_ready = !pending;
  assign cnt_d = slot_end ? '0 : cnt + 1'b1;
  assign nib = active[{dig, 2'b00} +: 4];
  ssd_hex_seg u_hex_seg (.hex(nib), .seg(seg));
`ifdef SSD_LZ_BLANK_EN
  // a digit is suppressed only if it and everything above it, digits and points alike, is blank
  assign lz_off = {active[15:12] == 4'h0 && !active_dp[3],
                   active[15:8] == 8'h0 && active_dp[3:2] == 2'b00,
                   active[15:4] == 12'h0 && active_dp[3:1] == 3'b000,
                   1'b0};
`else
  assign lz_off = '0;
`endif
  always_ff @(posedge clk)
    state <= reset ? BLANK : state_d;
  always_comb
    state_d = (cnt_d < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
  always_comb begin
    drive_en = state == DRIVE && !lz_off[dig];
    an_d = drive_en ? ~(4'b0001 << dig) : AN_OFF;
    cat_d = drive_en ? seg : SEG_OFF;
    dp_d = drive_en ? ~active_dp[dig] : 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      dig <= '0;
      active <= '0;
      active_dp <= '0;
      shadow <= '0;
      shadow_dp <= '0;
      pending <= 1'b0;
      Anode <= AN_OFF;
      Cathode <= SEG_OFF;
      dp <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (slot_end) dig <= dig + 1'b1;
      if (take) begin
        shadow <= wr.wr_data;
        shadow_dp <= wr.wr_dp;
        pending <= 1'b1;
      end
      if (commit) begin
        active <= shadow;
        active_dp <= shadow_dp;
        pending <= 1'b0;
      end
      Anode <= an_d;
      Cathode <= cat_d;
      dp <= dp_d;
      frame_start <= cnt == '0 && dig == '0;
    end
endmodule
